// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time from execute to byte-addressed data memory.
// Sub-word stores use read-modify-write; sub-word loads are extracted and extended.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   -> misaligned LH/LHU/SH/LW/SW respond with resp_err and no memory access
//   undefined -> misaligned accesses proceed as byte-addressed unaligned accesses
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE, rst low)
//   req_we, req_funct3       store flag, RV32I width code
//   req_addr, req_wdata      byte address, LSB-aligned store data
//   resp_valid/rdata/err     one-cycle completion pulse with load data / error flag
//   addr, dataW, memR, memW  registered memory pins
//   dataR                    memory read data (byte k = mem[addr+k])
module load_store_unit #(
    parameter int SIZE   = 12,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [SIZE-1:0] req_addr,
    input  logic [31:0]     req_wdata,
    output logic            resp_valid,
    output logic [31:0]     resp_rdata,
    output logic            resp_err,
    output logic [SIZE-1:0] addr,
    output logic [31:0]     dataW,
    output logic            memR,
    output logic            memW,
    input  logic [31:0]     dataR
);

    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t         r_state;
    logic [2:0]     r_f3;
    logic           r_we;
    logic [15:0]    r_wdata;
    logic [CW-1:0]  r_cnt;

    logic           w_accept;
    logic           w_illegal;
    logic           w_mis;
    logic           w_err;
    logic [31:0]    w_ext;
    logic [31:0]    w_merge;

    assign req_ready = (r_state == IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;

    always_comb begin
        w_illegal = 1'b0;
        if (req_we)
            w_illegal = (req_funct3 >= 3'b011);
        else
            w_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    end

`ifdef MISALIGN_TRAP_EN
    // Funct3 low bits 01 = halfword, 10 = word, for both loads and stores.
    always_comb begin
        w_mis = 1'b0;
        if (req_funct3[1:0] == 2'b01)
            w_mis = req_addr[0];
        else if (req_funct3[1:0] == 2'b10)
            w_mis = (req_addr[1:0] != 2'b00);
    end
`else
    assign w_mis = 1'b0;
`endif

    assign w_err = w_illegal || w_mis;

    // Extraction and merge act on the word coming back from memory,
    // which is captured into the response / write-data registers.
    always_comb begin
        w_ext = dataR;
        case (r_f3)
            3'b000:  w_ext = {{24{dataR[7]}}, dataR[7:0]};
            3'b001:  w_ext = {{16{dataR[15]}}, dataR[15:0]};
            3'b100:  w_ext = {24'd0, dataR[7:0]};
            3'b101:  w_ext = {16'd0, dataR[15:0]};
            default: w_ext = dataR;
        endcase
    end

    assign w_merge = r_f3[0] ? {dataR[31:16], r_wdata}
                             : {dataR[31:8], r_wdata[7:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_f3       <= 3'd0;
            r_we       <= 1'b0;
            r_wdata    <= 16'd0;
            r_cnt      <= '0;
            addr       <= '0;
            dataW      <= 32'd0;
            memR       <= 1'b0;
            memW       <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_f3    <= req_funct3;
                        r_we    <= req_we;
                        r_wdata <= req_wdata[15:0];
                        addr    <= req_addr;
                        if (w_err) begin
                            r_state    <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (req_we && req_funct3 == 3'b010) begin
                            r_state <= WR;
                            memW    <= 1'b1;
                            dataW   <= req_wdata;
                        end else begin
                            r_state <= RD;
                            memR    <= 1'b1;
                            r_cnt   <= CW'(RD_LAT - 1);
                        end
                    end
                end
                RD: begin
                    if (r_cnt == '0) begin
                        memR <= 1'b0;
                        if (r_we) begin
                            r_state <= WR;
                            memW    <= 1'b1;
                            dataW   <= w_merge;
                        end else begin
                            r_state    <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= w_ext;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                WR: begin
                    memW       <= 1'b0;
                    r_state    <= RESP;
                    resp_valid <= 1'b1;
                end
                default: begin
                    r_state    <= IDLE;
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'd0;
                    resp_err   <= 1'b0;
                    dataW      <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a byte-addressed memory model.
// Each step drives one request and checks latency, pin activity and response.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [11:0] req_addr = 12'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [11:0] addr;
    logic [31:0] dataW;
    logic        memR;
    logic        memW;
    logic [31:0] dataR;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mem [0:4095];

    load_store_unit #(.SIZE(12), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .addr(addr), .dataW(dataW), .memR(memR), .memW(memW),
        .dataR(dataR)
    );

    always #5 clk = ~clk;

    assign dataR = {mem[addr + 12'd3], mem[addr + 12'd2],
                    mem[addr + 12'd1], mem[addr]};

    always @(posedge clk) begin
        if (memW) begin
            mem[addr]          <= dataW[7:0];
            mem[addr + 12'd1]  <= dataW[15:8];
            mem[addr + 12'd2]  <= dataW[23:16];
            mem[addr + 12'd3]  <= dataW[31:24];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                       input logic [11:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int exp_lat, input int exp_nr, input int exp_nw,
                       input logic [31:0] exp_dw);
        int lat = -1;
        int nr = 0;
        int nw = 0;
        int nrdy = 0;
        int both = 0;
        logic [31:0] dw = 32'd0;
        logic [31:0] got_rd = 32'hxxxxxxxx;
        logic got_err = 1'bx;
        @(negedge clk);
        check({tag, " ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (memR) nr++;
            if (memW) begin
                nw++;
                dw = dataW;
            end
            if (memR && memW) both++;
            if (req_ready) nrdy++;
            if (resp_valid) begin
                lat     = n;
                got_rd  = resp_rdata;
                got_err = resp_err;
                break;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " rdata"}, got_rd, exp_rd);
        check({tag, " err"}, {31'd0, got_err}, {31'd0, exp_err});
        check({tag, " memR cycles"}, 32'(nr), 32'(exp_nr));
        check({tag, " memW cycles"}, 32'(nw), 32'(exp_nw));
        check({tag, " dataW"}, dw, exp_dw);
        check({tag, " R&W overlap"}, 32'(both), 32'd0);
        check({tag, " busy ready"}, 32'(nrdy), 32'd0);
        @(negedge clk);
        check({tag, " idle dataW"}, dataW, 32'd0);
        check({tag, " idle pins"}, {30'd0, memR, memW}, 32'd0);
        check({tag, " idle resp"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        int nw;
        int nv;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h010] = 8'h11;
        mem[12'h011] = 8'h22;
        mem[12'h012] = 8'h33;
        mem[12'h013] = 8'h84;
        mem[12'h014] = 8'h55;
        mem[12'hFFE] = 8'hA1;
        mem[12'hFFF] = 8'hB2;
        mem[12'h000] = 8'hC3;
        mem[12'h001] = 8'hD4;

        #2;
        check("rst ready", {31'd0, req_ready}, 32'd0);
        check("rst resp", {30'd0, resp_valid, resp_err}, 32'd0);
        check("rst rdata", resp_rdata, 32'd0);
        check("rst addr", {20'd0, addr}, 32'd0);
        check("rst dataW", dataW, 32'd0);
        check("rst pins", {30'd0, memR, memW}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-rst ready", {31'd0, req_ready}, 32'd1);

        txn("LW 10", 0, 3'b010, 12'h010, 0, 32'h84332211, 0, 2, 1, 0, 0);
        txn("LB 13", 0, 3'b000, 12'h013, 0, 32'hFFFFFF84, 0, 2, 1, 0, 0);
        txn("LBU 13", 0, 3'b100, 12'h013, 0, 32'h00000084, 0, 2, 1, 0, 0);
        txn("LH 12", 0, 3'b001, 12'h012, 0, 32'hFFFF8433, 0, 2, 1, 0, 0);
        txn("LHU 12", 0, 3'b101, 12'h012, 0, 32'h00008433, 0, 2, 1, 0, 0);
        txn("SB 10", 1, 3'b000, 12'h010, 32'hAABBCCEE, 0, 0, 3, 1, 1,
            32'h843322EE);
        txn("LW 10 after SB", 0, 3'b010, 12'h010, 0, 32'h843322EE, 0, 2, 1, 0, 0);
        txn("SW 20", 1, 3'b010, 12'h020, 32'hDEADBEEF, 0, 0, 2, 0, 1,
            32'hDEADBEEF);
        txn("LW 20", 0, 3'b010, 12'h020, 0, 32'hDEADBEEF, 0, 2, 1, 0, 0);
        txn("SH 20", 1, 3'b001, 12'h020, 32'h99991234, 0, 0, 3, 1, 1,
            32'hDEAD1234);
        txn("LW 20 after SH", 0, 3'b010, 12'h020, 0, 32'hDEAD1234, 0, 2, 1, 0, 0);
`ifdef MISALIGN_TRAP_EN
        txn("LW 11 trap", 0, 3'b010, 12'h011, 0, 32'h0, 1, 1, 0, 0, 0);
        txn("LW FFE trap", 0, 3'b010, 12'hFFE, 0, 32'h0, 1, 1, 0, 0, 0);
        txn("SH 21 trap", 1, 3'b001, 12'h021, 32'h5555, 0, 1, 1, 0, 0, 0);
`else
        txn("LW 11", 0, 3'b010, 12'h011, 0, 32'h55843322, 0, 2, 1, 0, 0);
        txn("LW FFE wrap", 0, 3'b010, 12'hFFE, 0, 32'hD4C3B2A1, 0, 2, 1, 0, 0);
        txn("LHU FFF wrap", 0, 3'b101, 12'hFFF, 0, 32'h0000C3B2, 0, 2, 1, 0, 0);
`endif
        txn("store f3=011", 1, 3'b011, 12'h030, 32'h12345678, 0, 1, 1, 0, 0, 0);
        txn("load f3=110", 0, 3'b110, 12'h010, 0, 32'h0, 1, 1, 0, 0, 0);
        txn("load f3=111", 0, 3'b111, 12'h010, 0, 32'h0, 1, 1, 0, 0, 0);
        txn("LBU FFF", 0, 3'b100, 12'hFFF, 0, 32'h000000B2, 0, 2, 1, 0, 0);

        // Reset during the RD cycle of an SB.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 12'h010;
        req_wdata  = 32'h00000099;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rst-mid memR before", {31'd0, memR}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst-mid pins drop", {30'd0, memR, memW}, 32'd0);
        check("rst-mid ready", {31'd0, req_ready}, 32'd0);
        nw = 0;
        nv = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (memW) nw++;
            if (resp_valid) nv++;
        end
        check("rst-mid memW", 32'(nw), 32'd0);
        check("rst-mid resp", 32'(nv), 32'd0);
        check("rst-mid mem", {mem[12'h013], mem[12'h012], mem[12'h011],
                              mem[12'h010]}, 32'h843322EE);
        txn("LW 10 after rst", 0, 3'b010, 12'h010, 0, 32'h843322EE, 0, 2, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
